// File: rtl/pkt_gen_chk_if.sv
// AXI-Stream beat bundle shared by the pattern generator (master) and
// the loopback checker (slave).
interface pkt_gen_chk_if #(
  parameter int DW = 64
) ();
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tstrb;
  logic            tvalid;
  logic            tready;
  logic            tlast;

  modport master (output tdata, output tstrb, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tstrb, input tvalid, input tlast, output tready);
endinterface

// File: rtl/pkt_gen_chk.sv
// AXI-Stream numbered-packet generator and loopback checker with
// saturating statistics, for link bring-up.
module pkt_gen_chk #(
  parameter int          C_M_AXIS_DATA_WIDTH = 64,
  parameter int          C_S_AXIS_DATA_WIDTH = 64,
  parameter int          C_CNT_WIDTH         = 32,
  parameter logic [63:0] C_SEED              = 64'hCAFEBEEFCAFEBEEF
) (
  input  logic                   axi_aclk,
  input  logic                   axi_aresetn,
  pkt_gen_chk_if.master          m_axis,
  pkt_gen_chk_if.slave           s_axis,
  input  logic                   cfg_enable,
  input  logic                   cfg_mode,
  input  logic [15:0]            cfg_pkt_words,
  input  logic [15:0]            cfg_ifg_words,
  input  logic [C_CNT_WIDTH-1:0] cfg_pkt_limit,
  input  logic                   count_reset,
  output logic                   gen_busy,
  output logic                   gen_done,
  output logic [C_CNT_WIDTH-1:0] tx_count,
  output logic [C_CNT_WIDTH-1:0] rx_count,
  output logic [C_CNT_WIDTH-1:0] err_count,
  output logic [C_CNT_WIDTH-1:0] seq_err_count
);

  localparam int                   DW      = C_M_AXIS_DATA_WIDTH;
  localparam int                   SDW     = C_S_AXIS_DATA_WIDTH;
  localparam int                   CW      = C_CNT_WIDTH;
  localparam logic [DW-1:0]        SEED    = DW'(C_SEED);
  localparam logic [DW-33:0]       SEED_HI = SEED[DW-1:32];
  localparam logic [CW-1:0]        CNT_ONE = CW'(1);

  function automatic logic [DW-1:0] ror1(input logic [DW-1:0] v);
    return {v[0], v[DW-1:1]};
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  typedef enum logic [1:0] {G_IDLE, G_PKT, G_IFG, G_DONE} gen_state_t;
  typedef enum logic [1:0] {C_IDLE, C_DATA, C_DROP}       chk_state_t;

  gen_state_t     gen_state, gen_nxt;
  logic [15:0]    gen_len, ifg_len, beat_idx, ifg_cnt;
  logic           gen_mode;
  logic [CW-1:0]  gen_limit, gen_sent;
  logic [31:0]    gen_seq;
  logic [DW-1:0]  gen_data;
  logic           gen_hs, gen_last, ifg_end, limit_hit, gen_start, gen_load;

  chk_state_t     chk_state, chk_nxt;
  logic [15:0]    chk_len, chk_idx, cfg_len_eff;
  logic           chk_mode, chk_err, synced;
  logic [SDW-1:0] chk_exp;
  logic [31:0]    exp_seq, rx_seq;
  logic           hi_bad, data_bad, chk_at_end;
  logic           rx_inc, err_inc, seq_inc;
  logic           unused_tstrb;

  assign cfg_len_eff = (cfg_pkt_words < 16'd2) ? 16'd2 : cfg_pkt_words;

  // ---------------- generator ----------------
  assign gen_hs    = (gen_state == G_PKT) && m_axis.tready;
  assign gen_last  = (beat_idx == gen_len - 16'd1);
  // An ifg of 0 still spends one cycle in IFG, giving the single idle gap.
  assign ifg_end   = ({1'b0, ifg_cnt} + 17'd1) >= {1'b0, ifg_len};
  assign limit_hit = (gen_limit != '0) && (gen_sent == gen_limit);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) gen_state <= G_IDLE;
    else              gen_state <= gen_nxt;
  end

  always_comb begin
    gen_nxt = gen_state;
    case (gen_state)
      G_IDLE: if (cfg_enable) gen_nxt = G_PKT;
      G_PKT:  if (gen_hs && gen_last) gen_nxt = G_IFG;
      G_IFG: begin
        if (ifg_end) begin
          if (limit_hit)       gen_nxt = G_DONE;
          else if (cfg_enable) gen_nxt = G_PKT;
          else                 gen_nxt = G_IDLE;
        end
      end
      G_DONE: if (!cfg_enable) gen_nxt = G_IDLE;
    endcase
  end

  assign gen_start = (gen_state == G_IDLE) && cfg_enable;
  assign gen_load  = (gen_nxt == G_PKT) && (gen_state != G_PKT);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      gen_len   <= '0;
      ifg_len   <= '0;
      gen_mode  <= 1'b0;
      gen_limit <= '0;
      gen_sent  <= '0;
      gen_seq   <= '0;
      beat_idx  <= '0;
      ifg_cnt   <= '0;
      gen_data  <= '0;
    end else begin
      if (gen_start) begin
        gen_len   <= cfg_len_eff;
        ifg_len   <= cfg_ifg_words;
        gen_mode  <= cfg_mode;
        gen_limit <= cfg_pkt_limit;
        gen_sent  <= '0;
        gen_seq   <= '0;
      end
      if (gen_load) begin
        beat_idx <= '0;
        gen_data <= {SEED_HI, gen_start ? 32'd0 : gen_seq};
      end else if (gen_hs) begin
        if (gen_last) begin
          gen_seq  <= gen_seq + 32'd1;
          gen_sent <= gen_sent + CNT_ONE;
          ifg_cnt  <= '0;
        end else begin
          beat_idx <= beat_idx + 16'd1;
          // Beat 1 restarts from the seed; beat 0 carries the sequence number.
          if (gen_mode)            gen_data <= DW'(beat_idx + 16'd1);
          else if (beat_idx == '0) gen_data <= ror1(SEED);
          else                     gen_data <= ror1(gen_data);
        end
      end else if (gen_state == G_IFG) begin
        ifg_cnt <= ifg_cnt + 16'd1;
      end
    end
  end

  assign m_axis.tvalid = (gen_state == G_PKT);
  assign m_axis.tdata  = gen_data;
  assign m_axis.tlast  = (gen_state == G_PKT) && gen_last;
  assign m_axis.tstrb  = (gen_state == G_PKT) ? '1 : '0;
  assign gen_busy      = (gen_state == G_PKT) || (gen_state == G_IFG);
  assign gen_done      = (gen_state == G_DONE);

  // ---------------- checker ----------------
  assign s_axis.tready = 1'b1;
  assign unused_tstrb  = ^s_axis.tstrb;
  assign rx_seq        = s_axis.tdata[31:0];
  assign hi_bad        = (s_axis.tdata[SDW-1:32] != SEED_HI);
  assign data_bad      = (s_axis.tdata != chk_exp);
  assign chk_at_end    = (chk_idx == chk_len - 16'd1);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) chk_state <= C_IDLE;
    else              chk_state <= chk_nxt;
  end

  always_comb begin
    chk_nxt = chk_state;
    rx_inc  = 1'b0;
    err_inc = 1'b0;
    seq_inc = 1'b0;
    case (chk_state)
      C_IDLE: begin
        if (s_axis.tvalid) begin
          seq_inc = synced && (rx_seq != exp_seq);
          if (s_axis.tlast) err_inc = 1'b1;
          else              chk_nxt = C_DATA;
        end
      end
      C_DATA: begin
        if (s_axis.tvalid) begin
          if (s_axis.tlast) begin
            chk_nxt = C_IDLE;
            if (chk_at_end && !chk_err && !data_bad) rx_inc  = 1'b1;
            else                                     err_inc = 1'b1;
          end else if (chk_at_end) begin
            chk_nxt = C_DROP;
          end
        end
      end
      C_DROP: begin
        if (s_axis.tvalid && s_axis.tlast) begin
          err_inc = 1'b1;
          chk_nxt = C_IDLE;
        end
      end
      default: chk_nxt = C_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      chk_len  <= '0;
      chk_idx  <= '0;
      chk_mode <= 1'b0;
      chk_err  <= 1'b0;
      chk_exp  <= '0;
      exp_seq  <= '0;
      synced   <= 1'b0;
    end else begin
      if (count_reset)                                 synced <= 1'b0;
      else if (chk_state == C_IDLE && s_axis.tvalid)   synced <= 1'b1;
      case (chk_state)
        C_IDLE: begin
          if (s_axis.tvalid) begin
            chk_len  <= cfg_len_eff;
            chk_mode <= cfg_mode;
            chk_err  <= hi_bad;
            chk_idx  <= 16'd1;
            chk_exp  <= cfg_mode ? SDW'(1) : ror1(SEED);
            exp_seq  <= rx_seq + 32'd1;
          end
        end
        C_DATA: begin
          if (s_axis.tvalid && !s_axis.tlast) begin
            chk_err <= chk_err | data_bad;
            chk_idx <= chk_idx + 16'd1;
            chk_exp <= chk_mode ? SDW'(chk_idx + 16'd1) : ror1(chk_exp);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- statistics ----------------
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      tx_count      <= '0;
      rx_count      <= '0;
      err_count     <= '0;
      seq_err_count <= '0;
    end else if (count_reset) begin
      tx_count      <= '0;
      rx_count      <= '0;
      err_count     <= '0;
      seq_err_count <= '0;
    end else begin
      if (gen_hs && gen_last) tx_count      <= sat_inc(tx_count);
      if (rx_inc)             rx_count      <= sat_inc(rx_count);
      if (err_inc)            err_count     <= sat_inc(err_count);
      if (seq_inc)            seq_err_count <= sat_inc(seq_err_count);
    end
  end

endmodule

// File: tb/tb_pkt_gen_chk.sv
// Directed bench for pkt_gen_chk: generator beats go through an
// expected-beat scoreboard; checker statistics are compared per scenario.
module tb_pkt_gen_chk;
  localparam int          DW   = 64;
  localparam int          CW   = 32;
  localparam logic [63:0] SEED = 64'hCAFEBEEFCAFEBEEF;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cfg_enable = 1'b0, cfg_mode = 1'b0, count_reset = 1'b0;
  logic [15:0]   cfg_pkt_words = 16'd4, cfg_ifg_words = 16'd0;
  logic [CW-1:0] cfg_pkt_limit = '0;
  logic          gen_busy, gen_done;
  logic [CW-1:0] tx_count, rx_count, err_count, seq_err_count;

  logic          tready_drv = 1'b1, toggle_en = 1'b0;
  logic          inj_en = 1'b0, inj_valid = 1'b0, inj_last = 1'b0;
  logic [DW-1:0] inj_data = '0;
  logic          corrupt_en = 1'b0, lb_clr = 1'b0;
  int unsigned   lb_pkt = 0, lb_beat = 0;
  logic [DW-1:0] flip;

  int    checks = 0, errors = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  pkt_gen_chk_if #(.DW(DW)) m_axis ();
  pkt_gen_chk_if #(.DW(DW)) s_axis ();

  pkt_gen_chk #(
    .C_M_AXIS_DATA_WIDTH(DW),
    .C_S_AXIS_DATA_WIDTH(DW),
    .C_CNT_WIDTH(CW),
    .C_SEED(SEED)
  ) dut (
    .axi_aclk(clk),
    .axi_aresetn(rstn),
    .m_axis(m_axis),
    .s_axis(s_axis),
    .cfg_enable(cfg_enable),
    .cfg_mode(cfg_mode),
    .cfg_pkt_words(cfg_pkt_words),
    .cfg_ifg_words(cfg_ifg_words),
    .cfg_pkt_limit(cfg_pkt_limit),
    .count_reset(count_reset),
    .gen_busy(gen_busy),
    .gen_done(gen_done),
    .tx_count(tx_count),
    .rx_count(rx_count),
    .err_count(err_count),
    .seq_err_count(seq_err_count)
  );

  assign m_axis.tready = tready_drv;
  assign flip = (corrupt_en && lb_pkt == 1 && lb_beat == 2) ? 64'd1 : 64'd0;

  // Loopback path (only handshaken beats) or directly injected packets.
  always_comb begin
    if (inj_en) begin
      s_axis.tdata  = inj_data;
      s_axis.tstrb  = '1;
      s_axis.tvalid = inj_valid;
      s_axis.tlast  = inj_last;
    end else begin
      s_axis.tdata  = m_axis.tdata ^ flip;
      s_axis.tstrb  = m_axis.tstrb;
      s_axis.tvalid = m_axis.tvalid && m_axis.tready;
      s_axis.tlast  = m_axis.tlast;
    end
  end

  always @(posedge clk) begin
    if (lb_clr) begin
      lb_pkt  <= 0;
      lb_beat <= 0;
    end else if (m_axis.tvalid && m_axis.tready) begin
      if (m_axis.tlast) begin
        lb_pkt  <= lb_pkt + 1;
        lb_beat <= 0;
      end else begin
        lb_beat <= lb_beat + 1;
      end
    end
  end

  function automatic logic [DW-1:0] exp_beat(input logic [31:0] s, input int unsigned k, input bit mode);
    logic [DW-1:0] r;
    if (k == 0) return {SEED[63:32], s};
    if (mode) return DW'(k);
    r = SEED;
    for (int unsigned i = 0; i < k; i++) r = {r[0], r[DW-1:1]};
    return r;
  endfunction

  task automatic push_pkts(input int unsigned n, input logic [15:0] words, input bit mode);
    int unsigned len;
    beat_t b;
    len = (words < 16'd2) ? 2 : int'(words);
    for (int unsigned p = 0; p < n; p++)
      for (int unsigned k = 0; k < len; k++) begin
        b.data = exp_beat(p, k, mode);
        b.last = (k == len - 1);
        exp_q.push_back(b);
      end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Generator monitor: every valid cycle (stalled or not) must present the
  // head of the expected-beat queue; it is popped on handshake.
  always @(negedge clk) begin
    if (rstn && m_axis.tvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got data %h last %b with empty queue", m_axis.tdata, m_axis.tlast);
      end else begin
        if (m_axis.tdata !== exp_q[0].data || m_axis.tlast !== exp_q[0].last) begin
          errors++;
          $display("FAIL beat: got data %h last %b expected data %h last %b",
                   m_axis.tdata, m_axis.tlast, exp_q[0].data, exp_q[0].last);
        end
        if (m_axis.tready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) tready_drv = ~tready_drv;
      else           tready_drv = 1'b1;
    end
  end

  task automatic pulse_clear();
    count_reset = 1'b1;
    lb_clr      = 1'b1;
    @(negedge clk);
    count_reset = 1'b0;
    lb_clr      = 1'b0;
  endtask

  task automatic run(input logic [15:0] words, input logic [15:0] ifg, input logic [31:0] limit, input bit mode);
    cfg_pkt_words = words;
    cfg_ifg_words = ifg;
    cfg_pkt_limit = limit;
    cfg_mode      = mode;
    pulse_clear();
    push_pkts(limit, words, mode);
    cfg_enable = 1'b1;
    for (int unsigned i = 0; i < 2000 && !gen_done; i++) @(negedge clk);
    chk("gen_done", gen_done, 1);
    chk("gen_busy_in_done", gen_busy, 0);
    cfg_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("gen_done_clear", gen_done, 0);
    chk("q_drained", exp_q.size(), 0);
  endtask

  task automatic send(input logic [31:0] s, input int unsigned n, input bit cr_last);
    for (int unsigned k = 0; k < n; k++) begin
      inj_data    = exp_beat(s, k, 1'b0);
      inj_last    = (k == n - 1);
      inj_valid   = 1'b1;
      count_reset = cr_last && (k == n - 1);
      @(negedge clk);
    end
    inj_valid   = 1'b0;
    inj_last    = 1'b0;
    count_reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tvalid", m_axis.tvalid, 0);
    chk("rst_tstrb", m_axis.tstrb, 0);
    chk("rst_tlast", m_axis.tlast, 0);
    chk("rst_s_tready", s_axis.tready, 1);
    chk("rst_busy", gen_busy, 0);
    chk("rst_done", gen_done, 0);
    chk("rst_tx", tx_count, 0);
    chk("rst_rx", rx_count, 0);
    chk("rst_err", err_count, 0);
    chk("rst_seq", seq_err_count, 0);
    rstn = 1'b1;
    @(negedge clk);

    // 1: basic loopback, mode 0
    run(16'd4, 16'd2, 32'd3, 1'b0);
    chk("t1_tx", tx_count, 3);
    chk("t1_rx", rx_count, 3);
    chk("t1_err", err_count, 0);
    chk("t1_seq", seq_err_count, 0);

    // 2: tready toggling, 1-word length clamps to 2, zero gap
    toggle_en = 1'b1;
    run(16'd1, 16'd0, 32'd3, 1'b0);
    toggle_en = 1'b0;
    chk("t2_tx", tx_count, 3);
    chk("t2_rx", rx_count, 3);
    chk("t2_err", err_count, 0);

    // 3: flip bit 0 of beat 2 of packet 1 on the loopback
    corrupt_en = 1'b1;
    run(16'd4, 16'd2, 32'd3, 1'b0);
    corrupt_en = 1'b0;
    chk("t3_tx", tx_count, 3);
    chk("t3_rx", rx_count, 2);
    chk("t3_err", err_count, 1);

    // 4: sequence jump 1 -> 5 -> 6
    inj_en        = 1'b1;
    cfg_pkt_words = 16'd4;
    cfg_mode      = 1'b0;
    pulse_clear();
    send(32'd1, 4, 1'b0);
    send(32'd5, 4, 1'b0);
    send(32'd6, 4, 1'b0);
    chk("t4_seq", seq_err_count, 1);
    chk("t4_rx", rx_count, 3);
    chk("t4_err", err_count, 0);

    // 5: early tlast, late tlast, then a good packet
    pulse_clear();
    send(32'd10, 3, 1'b0);
    send(32'd11, 6, 1'b0);
    send(32'd12, 4, 1'b0);
    chk("t5_err", err_count, 2);
    chk("t5_rx", rx_count, 1);
    chk("t5_seq", seq_err_count, 0);

    // 6a: count_reset coincides with a good-packet increment
    send(32'd13, 4, 1'b1);
    chk("t6_tx", tx_count, 0);
    chk("t6_rx", rx_count, 0);
    chk("t6_err", err_count, 0);
    chk("t6_seq", seq_err_count, 0);
    send(32'd99, 4, 1'b0);
    chk("t6_unsynced_seq", seq_err_count, 0);
    chk("t6_unsynced_rx", rx_count, 1);

    // 6b: drop cfg_enable mid-packet in continuous mode 1
    inj_en        = 1'b0;
    cfg_pkt_words = 16'd6;
    cfg_ifg_words = 16'd3;
    cfg_pkt_limit = '0;
    cfg_mode      = 1'b1;
    pulse_clear();
    push_pkts(1, 16'd6, 1'b1);
    cfg_enable = 1'b1;
    for (int unsigned i = 0; i < 100 && !(lb_pkt == 0 && lb_beat == 2); i++) @(negedge clk);
    chk("t6b_mid_pkt", gen_busy, 1);
    cfg_enable = 1'b0;
    for (int unsigned i = 0; i < 100 && gen_busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("t6b_idle", gen_busy, 0);
    chk("t6b_done", gen_done, 0);
    chk("t6b_tx", tx_count, 1);
    chk("t6b_rx", rx_count, 1);
    chk("t6b_err", err_count, 0);
    chk("t6b_q", exp_q.size(), 0);

    // 7: asynchronous reset mid-packet
    cfg_pkt_words = 16'd8;
    cfg_ifg_words = 16'd0;
    cfg_mode      = 1'b0;
    pulse_clear();
    push_pkts(1, 16'd8, 1'b0);
    cfg_enable = 1'b1;
    for (int unsigned i = 0; i < 100 && lb_beat != 3; i++) @(negedge clk);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("t7_tvalid_drop", m_axis.tvalid, 0);
    exp_q.delete();
    cfg_enable = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("t7_tx", tx_count, 0);
    chk("t7_rx", rx_count, 0);
    chk("t7_err", err_count, 0);
    run(16'd4, 16'd0, 32'd2, 1'b0);
    chk("t7_after_rx", rx_count, 2);
    chk("t7_after_err", err_count, 0);
    chk("t7_after_seq", seq_err_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
